// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix multiplier datapath: FP32 field layout,
// streamer state encoding and the flat-matrix element offset helper.
package matrix_pkg;

  localparam int ELEMENT_LENGTH = 32;
  localparam int EXP_W          = 8;
  localparam int MANT_W         = 23;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  localparam logic [0:0] STREAMER_IDLE   = 1'b0;
  localparam logic [0:0] STREAMER_STREAM = 1'b1;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } fp32_t;

  // MSB position of element (r,c) in a row-major flat matrix with (0,0) in the MSBs.
  function automatic int elem_msb(input int r, input int c, input int ncol, input int total);
    return total - 1 - ELEMENT_LENGTH * (r * ncol + c);
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/matrix_result_streamer_if.sv
// Capture handshake from the multiplier plus the element stream to the consumer.
interface matrix_result_streamer_if #(
  parameter int NUM_ROW = 2,
  parameter int NUM_COL = 2
);
  import matrix_pkg::*;

  localparam int NUM_ELEM   = NUM_ROW * NUM_COL;
  localparam int MAT_LENGTH = ELEMENT_LENGTH * NUM_ELEM;
  localparam int ROW_W      = idx_width(NUM_ROW);
  localparam int COL_W      = idx_width(NUM_COL);

  logic [MAT_LENGTH-1:0]     mat_in;
  logic                      mat_ready;
  logic                      mat_ack;
  logic [ELEMENT_LENGTH-1:0] elem_out;
  logic                      elem_valid;
  logic                      elem_ready;
  logic [ROW_W-1:0]          elem_row;
  logic [COL_W-1:0]          elem_col;
  logic                      elem_last;
  logic                      elem_nan;
  logic                      elem_inf;
  logic                      elem_zero;

  modport master (
    output mat_in, mat_ready, elem_ready,
    input  mat_ack, elem_out, elem_valid, elem_row, elem_col,
           elem_last, elem_nan, elem_inf, elem_zero
  );

  modport slave (
    input  mat_in, mat_ready, elem_ready,
    output mat_ack, elem_out, elem_valid, elem_row, elem_col,
           elem_last, elem_nan, elem_inf, elem_zero
  );

endinterface

// File: rtl/matrix_result_streamer_fp32_classify.sv
// Combinational IEEE-754 single-precision classifier (NaN / Inf / signed zero).
module fp32_classify
  import matrix_pkg::*;
(
  input  logic [ELEMENT_LENGTH-1:0] value,
  output logic                      is_nan,
  output logic                      is_inf,
  output logic                      is_zero
);

  logic [EXP_W-1:0]  exp_f;
  logic [MANT_W-1:0] mant_f;

  assign exp_f  = value[MANT_W +: EXP_W];
  assign mant_f = value[MANT_W-1:0];

  assign is_nan  = (exp_f == EXP_MAX) && (mant_f != '0);
  assign is_inf  = (exp_f == EXP_MAX) && (mant_f == '0);
  // Shifting out the sign makes +0 and -0 compare equal.
  assign is_zero = ((value << 1) == '0);

endmodule

// File: rtl/matrix_result_streamer.sv
// Captures a finished product matrix and streams its FP32 elements row-major
// over valid/ready with row/col indices, last marker and special-value flags.
module matrix_result_streamer
  import matrix_pkg::*;
#(
  parameter int NUM_ROW = 2,
  parameter int NUM_COL = 2
) (
  input  logic clk,
  input  logic rst,
  matrix_result_streamer_if.slave bus
);
  // state            | meaning
  // STREAMER_IDLE    | waiting for mat_ready; no beat presented
  // STREAMER_STREAM  | matrix buffered; presenting element idx until last beat is taken

  localparam int NUM_ELEM   = NUM_ROW * NUM_COL;
  localparam int MAT_LENGTH = ELEMENT_LENGTH * NUM_ELEM;
  localparam int IDX_W      = idx_width(NUM_ELEM);
  localparam int ROW_W      = idx_width(NUM_ROW);
  localparam int COL_W      = idx_width(NUM_COL);

  logic [0:0]                state;
  logic [MAT_LENGTH-1:0]     mat_buf;
  logic [IDX_W-1:0]          idx;
  logic [ROW_W-1:0]          row;
  logic [COL_W-1:0]          col;
  logic                      ack;
  logic                      streaming;
  logic                      last_elem;
  logic [ELEMENT_LENGTH-1:0] elem;
  logic [ELEMENT_LENGTH-1:0] elems [NUM_ELEM];

  for (genvar g = 0; g < NUM_ELEM; g++) begin : g_split
    assign elems[g] = mat_buf[elem_msb(g / NUM_COL, g % NUM_COL, NUM_COL, MAT_LENGTH) -: ELEMENT_LENGTH];
  end

  assign elem      = elems[idx];
  assign streaming = (state == STREAMER_STREAM);
  assign last_elem = (idx == IDX_W'(NUM_ELEM - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= STREAMER_IDLE;
      mat_buf <= '0;
      idx     <= '0;
      row     <= '0;
      col     <= '0;
      ack     <= 1'b0;
    end else begin
      ack <= 1'b0;
      case (state)
        STREAMER_IDLE: begin
          if (bus.mat_ready) begin
            mat_buf <= bus.mat_in;
            ack     <= 1'b1;
            idx     <= '0;
            row     <= '0;
            col     <= '0;
            state   <= STREAMER_STREAM;
          end
        end
        STREAMER_STREAM: begin
          if (bus.elem_ready) begin
            if (last_elem) begin
              idx   <= '0;
              row   <= '0;
              col   <= '0;
              state <= STREAMER_IDLE;
            end else begin
              idx <= idx + IDX_W'(1);
              if (col == COL_W'(NUM_COL - 1)) begin
                col <= '0;
                row <= row + ROW_W'(1);
              end else begin
                col <= col + COL_W'(1);
              end
            end
          end
        end
        default: state <= STREAMER_IDLE;
      endcase
    end
  end

  fp32_classify u_classify (
    .value   (elem),
    .is_nan  (bus.elem_nan),
    .is_inf  (bus.elem_inf),
    .is_zero (bus.elem_zero)
  );

  assign bus.mat_ack    = ack;
  assign bus.elem_out   = elem;
  assign bus.elem_valid = streaming;
  assign bus.elem_row   = row;
  assign bus.elem_col   = col;
  assign bus.elem_last  = streaming && last_elem;

endmodule

// File: tb/tb_matrix_result_streamer.sv
// Bench for matrix_result_streamer: 2x2 and 1x3 instances checked every cycle
// against a queue-based beat model, plus directed literal checks.
module tb_matrix_result_streamer;
  import matrix_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  matrix_result_streamer_if #(.NUM_ROW(2), .NUM_COL(2)) ifa ();
  matrix_result_streamer_if #(.NUM_ROW(1), .NUM_COL(3)) ifb ();

  matrix_result_streamer #(.NUM_ROW(2), .NUM_COL(2)) dut_a (.clk(clk), .rst(rst_n), .bus(ifa));
  matrix_result_streamer #(.NUM_ROW(1), .NUM_COL(3)) dut_b (.clk(clk), .rst(rst_n), .bus(ifb));

  typedef struct {
    logic        valid, ack, last, nan, inf, zero;
    logic [31:0] data;
    int          row, col;
  } snap_t;

  typedef struct {
    logic [31:0] data;
    int          row, col;
    bit          last;
  } beat_t;

  int    checks = 0;
  int    errors = 0;
  int    nr[2] = '{2, 1};
  int    nc[2] = '{2, 3};
  beat_t exp_q [2][$];
  snap_t log_q [2][$];
  logic  exp_ack[2] = '{1'b0, 1'b0};
  bit    fresh[2] = '{1'b1, 1'b1};
  int    ack_cnt[2] = '{0, 0};
  logic  bp_pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  localparam logic [127:0] M1 = {32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
  localparam logic [127:0] M2 = {32'h41000000, 32'h41100000, 32'h41200000, 32'h41300000};
  localparam logic [127:0] MS = {32'h7FC00000, 32'h7F800000, 32'h80000000, 32'h3F800000};
  localparam logic [127:0] MB = {32'h0, 32'h40A00000, 32'h40C00000, 32'h40E00000};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT at %0t", name, $time);
  endtask

  function automatic snap_t peek(input int d);
    snap_t s;
    if (d == 0) begin
      s.valid = ifa.elem_valid; s.ack = ifa.mat_ack; s.last = ifa.elem_last;
      s.nan = ifa.elem_nan; s.inf = ifa.elem_inf; s.zero = ifa.elem_zero;
      s.data = ifa.elem_out; s.row = int'(ifa.elem_row); s.col = int'(ifa.elem_col);
    end else begin
      s.valid = ifb.elem_valid; s.ack = ifb.mat_ack; s.last = ifb.elem_last;
      s.nan = ifb.elem_nan; s.inf = ifb.elem_inf; s.zero = ifb.elem_zero;
      s.data = ifb.elem_out; s.row = int'(ifb.elem_row); s.col = int'(ifb.elem_col);
    end
    return s;
  endfunction

  function automatic logic mr_of(input int d);
    return (d == 0) ? ifa.mat_ready : ifb.mat_ready;
  endfunction

  function automatic logic er_of(input int d);
    return (d == 0) ? ifa.elem_ready : ifb.elem_ready;
  endfunction

  function automatic logic [127:0] min_of(input int d);
    return (d == 0) ? ifa.mat_in : {32'h0, ifb.mat_in};
  endfunction

  task automatic set_mat(input int d, input logic [127:0] m);
    if (d == 0) ifa.mat_in = m; else ifb.mat_in = m[95:0];
  endtask

  task automatic set_mr(input int d, input logic v);
    if (d == 0) ifa.mat_ready = v; else ifb.mat_ready = v;
  endtask

  task automatic set_er(input int d, input logic v);
    if (d == 0) ifa.elem_ready = v; else ifb.elem_ready = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Element e (row-major) of a flat matrix whose first element is in the MSBs.
  function automatic logic [31:0] elem_of(input logic [127:0] m, input int d, input int e);
    int total;
    total = 32 * nr[d] * nc[d];
    return 32'(m >> (total - 32 * (e + 1)));
  endfunction

  function automatic logic [2:0] flags_of(input logic [31:0] x);
    fp32_t f;
    f = x;
    return {(f.exp == 8'hFF) && (f.mant != 0), (f.exp == 8'hFF) && (f.mant == 0),
            (f.exp == 0) && (f.mant == 0)};
  endfunction

  function automatic logic rdy(input int mode, input int k);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (k < 7) ? bp_pat[k] : 1'b1;
    return 1'b1 & $urandom_range(0, 1);
  endfunction

  function automatic logic [31:0] rand_elem();
    case ($urandom_range(0, 5))
      0: return {$urandom_range(0, 1) == 1, 31'h7F800000};
      1: return {1'b0, 8'hFF, 23'($urandom_range(1, 32'h7FFFFF))};
      2: return {$urandom_range(0, 1) == 1, 31'h0};
      3: return {1'b0, 8'h00, 23'($urandom_range(1, 32'h7FFFFF))};
      default: return $urandom;
    endcase
  endfunction

  // Beat-level model: a captured matrix becomes a queue of expected beats.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin : model
      snap_t       s;
      beat_t       h;
      beat_t       b;
      bit          ev;
      string       p;
      logic [2:0]  fl;
      s  = peek(d);
      p  = (d == 0) ? "a." : "b.";
      ev = (exp_q[d].size() > 0);
      chk({p, "valid"}, 32'(s.valid), 32'(ev));
      chk({p, "ack"}, 32'(s.ack), 32'(exp_ack[d]));
      if (ev) begin
        h  = exp_q[d][0];
        fl = flags_of(h.data);
        chk({p, "data"}, s.data, h.data);
        chk({p, "row"}, 32'(s.row), 32'(h.row));
        chk({p, "col"}, 32'(s.col), 32'(h.col));
        chk({p, "last"}, 32'(s.last), 32'(h.last));
        chk({p, "nan"}, 32'(s.nan), 32'(fl[2]));
        chk({p, "inf"}, 32'(s.inf), 32'(fl[1]));
        chk({p, "zero"}, 32'(s.zero), 32'(fl[0]));
      end else begin
        chk({p, "idle_row"}, 32'(s.row), 32'd0);
        chk({p, "idle_col"}, 32'(s.col), 32'd0);
        if (fresh[d]) begin
          chk({p, "rst_data"}, s.data, 32'd0);
          chk({p, "rst_last"}, 32'(s.last), 32'd0);
          chk({p, "rst_nan"}, 32'(s.nan), 32'd0);
          chk({p, "rst_inf"}, 32'(s.inf), 32'd0);
          chk({p, "rst_zero"}, 32'(s.zero), 32'd1);
        end
      end
      if (s.ack) ack_cnt[d]++;
      if (s.valid && er_of(d)) log_q[d].push_back(s);
      exp_ack[d] = 1'b0;
      if (!rst_n) begin
        exp_q[d].delete();
        fresh[d] = 1'b1;
      end else if (!ev && mr_of(d)) begin
        for (int e = 0; e < nr[d] * nc[d]; e++) begin
          b.data = elem_of(min_of(d), d, e);
          b.row  = e / nc[d];
          b.col  = e % nc[d];
          b.last = (e == nr[d] * nc[d] - 1);
          exp_q[d].push_back(b);
        end
        exp_ack[d] = 1'b1;
        fresh[d]   = 1'b0;
      end else if (ev && er_of(d)) begin
        void'(exp_q[d].pop_front());
      end
    end
  end

  task automatic run(input int d, input logic [127:0] m, input int mode,
                     output int vcyc, output int ackt);
    int t;
    snap_t s;
    vcyc = 0;
    ackt = -1;
    set_mat(d, m);
    set_mr(d, 1'b1);
    set_er(d, rdy(mode, 0));
    for (t = 1; t <= 100; t++) begin
      tick();
      s = peek(d);
      if (s.ack) begin
        ackt = t;
        set_mr(d, 1'b0);
      end
      if (s.valid) begin
        vcyc++;
        set_er(d, rdy(mode, vcyc));
      end else if (vcyc > 0) begin
        break;
      end
    end
    if (t > 100) begin
      fail_now("run_stream");
      set_mr(d, 1'b0);
    end
  endtask

  logic [31:0] lit_m1[4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
  logic [31:0] lit_m2[4] = '{32'h41000000, 32'h41100000, 32'h41200000, 32'h41300000};
  int          lit_row[4] = '{0, 0, 1, 1};
  int          lit_col[4] = '{0, 1, 0, 1};

  initial begin
    int    v, at, a0, n;
    snap_t s;
    rst_n = 1'b0;
    ifa.mat_in = '0; ifa.mat_ready = 1'b0; ifa.elem_ready = 1'b0;
    ifb.mat_in = '0; ifb.mat_ready = 1'b0; ifb.elem_ready = 1'b0;
    repeat (3) tick();
    s = peek(0);
    chk("reset_valid", 32'(s.valid), 32'd0);
    chk("reset_ack", 32'(s.ack), 32'd0);
    chk("reset_zero", 32'(s.zero), 32'd1);
    rst_n = 1'b1;
    tick();

    // basic 2x2 stream with ready held high
    log_q[0].delete();
    a0 = ack_cnt[0];
    run(0, M1, 0, v, at);
    chk("t1_valid_cycles", 32'(v), 32'd4);
    chk("t1_ack_latency", 32'(at), 32'd1);
    chk("t1_ack_pulses", 32'(ack_cnt[0] - a0), 32'd1);
    chk("t1_beats", 32'(log_q[0].size()), 32'd4);
    for (int i = 0; i < 4 && i < log_q[0].size(); i++) begin
      chk("t1_data", log_q[0][i].data, lit_m1[i]);
      chk("t1_row", 32'(log_q[0][i].row), 32'(lit_row[i]));
      chk("t1_col", 32'(log_q[0][i].col), 32'(lit_col[i]));
      chk("t1_last", 32'(log_q[0][i].last), 32'(i == 3));
    end

    // backpressure 1,0,0,1,0,1,1
    log_q[0].delete();
    run(0, M1, 1, v, at);
    chk("t2_valid_cycles", 32'(v), 32'd7);
    chk("t2_beats", 32'(log_q[0].size()), 32'd4);
    for (int i = 0; i < 4 && i < log_q[0].size(); i++)
      chk("t2_data", log_q[0][i].data, lit_m1[i]);

    // special-value flags
    log_q[0].delete();
    run(0, MS, 0, v, at);
    chk("t3_beats", 32'(log_q[0].size()), 32'd4);
    for (int i = 0; i < 4 && i < log_q[0].size(); i++) begin
      chk("t3_nan", 32'(log_q[0][i].nan), 32'(i == 0));
      chk("t3_inf", 32'(log_q[0][i].inf), 32'(i == 1));
      chk("t3_zero", 32'(log_q[0][i].zero), 32'(i == 2));
    end

    // reset after beat 1 accepted, then reset together with mat_ready
    log_q[0].delete();
    set_mat(0, M1); set_mr(0, 1'b1); set_er(0, 1'b1);
    tick();
    set_mr(0, 1'b0);
    tick();
    tick();
    chk("t4_beats_before_rst", 32'(log_q[0].size()), 32'd2);
    rst_n = 1'b0;
    set_mr(0, 1'b1);
    tick();
    s = peek(0);
    chk("t4_valid", 32'(s.valid), 32'd0);
    chk("t4_ack", 32'(s.ack), 32'd0);
    chk("t4_row", 32'(s.row), 32'd0);
    chk("t4_col", 32'(s.col), 32'd0);
    chk("t4_zero", 32'(s.zero), 32'd1);
    tick();
    s = peek(0);
    chk("t4_rst_vs_ready_ack", 32'(s.ack), 32'd0);
    rst_n = 1'b1;
    set_mr(0, 1'b0);
    tick();
    log_q[0].delete();
    run(0, M2, 0, v, at);
    chk("t4_restream_beats", 32'(log_q[0].size()), 32'd4);
    if (log_q[0].size() > 0) begin
      chk("t4_first_data", log_q[0][0].data, 32'h41000000);
      chk("t4_first_row", 32'(log_q[0][0].row), 32'd0);
      chk("t4_first_col", 32'(log_q[0][0].col), 32'd0);
    end

    // back-to-back: mat_ready rises in the cycle of the last transfer
    log_q[0].delete();
    a0 = ack_cnt[0];
    set_mat(0, M1); set_mr(0, 1'b1); set_er(0, 1'b1);
    n = 0;
    do begin tick(); n++; end while (!peek(0).ack && n < 20);
    if (n >= 20) fail_now("t5_ack1");
    set_mr(0, 1'b0);
    n = 0;
    while (!(peek(0).valid && peek(0).last) && n < 20) begin tick(); n++; end
    if (n >= 20) fail_now("t5_last1");
    set_mat(0, M2); set_mr(0, 1'b1);
    tick();
    s = peek(0);
    chk("t5_gap_valid", 32'(s.valid), 32'd0);
    chk("t5_gap_ack", 32'(s.ack), 32'd0);
    tick();
    s = peek(0);
    chk("t5_capture_ack", 32'(s.ack), 32'd1);
    chk("t5_capture_valid", 32'(s.valid), 32'd1);
    set_mr(0, 1'b0);
    n = 0;
    while (peek(0).valid && n < 20) begin tick(); n++; end
    if (n >= 20) fail_now("t5_drain");
    chk("t5_beats", 32'(log_q[0].size()), 32'd8);
    for (int i = 0; i < 8 && i < log_q[0].size(); i++)
      chk("t5_data", log_q[0][i].data, (i < 4) ? lit_m1[i] : lit_m2[i - 4]);
    chk("t5_ack_pulses", 32'(ack_cnt[0] - a0), 32'd2);

    // 1x3 instance
    log_q[1].delete();
    run(1, MB, 0, v, at);
    chk("t6_valid_cycles", 32'(v), 32'd3);
    chk("t6_beats", 32'(log_q[1].size()), 32'd3);
    for (int i = 0; i < 3 && i < log_q[1].size(); i++) begin
      chk("t6_row", 32'(log_q[1][i].row), 32'd0);
      chk("t6_col", 32'(log_q[1][i].col), 32'(i));
      chk("t6_last", 32'(log_q[1][i].last), 32'(i == 2));
    end
    if (log_q[1].size() == 3) chk("t6_data2", log_q[1][2].data, 32'h40E00000);

    // randomized traffic on both instances, occasional resets
    for (int c = 0; c < 1500; c++) begin
      tick();
      rst_n = ($urandom_range(0, 149) != 0);
      for (int d = 0; d < 2; d++) begin
        if (mr_of(d)) begin
          if (peek(d).ack) set_mr(d, 1'b0);
        end else if ($urandom_range(0, 2) == 0) begin
          set_mat(d, {rand_elem(), rand_elem(), rand_elem(), rand_elem()});
          set_mr(d, 1'b1);
        end
        set_er(d, $urandom_range(0, 3) != 0);
      end
    end
    rst_n = 1'b1;
    set_mr(0, 1'b0); set_mr(1, 1'b0);
    set_er(0, 1'b1); set_er(1, 1'b1);
    repeat (20) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
